buckeye_shift_ctrl: RTL and testbench
=====================================

Name: buckeye_shift_ctrl

Overview:
- Controls the serial configuration shift registers of the six Buckeye amplifier chips. Each chip has a 48-bit register: 16 channels × 3 mode bits.
- Holds one pattern register per chip, written from the slow-control side. On START it shifts the patterns out MSB-first on TO_BKY with a divided clock on BKY_CLK.
- Captures the bits each chip returns on BKY_RTN into a readback register.
- Sits directly upstream of the pad buffer stage, which drives TO_BKY and BKY_CLK and returns BKY_RTN.

Parameters:
- NCHIP, 6, number of Buckeye chips; ports are indexed [NCHIP:1].
- NBITS, 48, shift-register length per chip.
- CLK_DIV, 4, length of each BKY_CLK phase (low or high) in CLK cycles; legal minimum is 3.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST_B  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle pulse that begins a shift cycle on all unmasked chips.
- CHIP_MASK  input  [NCHIP:1]  1 = chip takes part in the shift; sampled on START.
- WR_EN  input  1  write strobe for a pattern register.
- WR_CHIP  input  3  chip index for the write, 1..NCHIP.
- WR_DATA  input  NBITS  pattern to be loaded.
- RD_CHIP  input  3  chip index for readback, 1..NCHIP.
- RD_DATA  output  NBITS  readback register of chip RD_CHIP.
- BUSY  output  1  high while a shift is in progress.
- DONE  output  1  one-cycle pulse when a shift completes.
- TO_BKY  output  [NCHIP:1]  serial data to each chip.
- BKY_CLK  output  [NCHIP:1]  shift clock to each chip.
- BKY_RTN  input  [NCHIP:1]  serial return from each chip; asynchronous to CLK.

Behaviour:
- Reset (RST_B=0, asynchronous):
  - State machine goes to IDLE.
  - TO_BKY, BKY_CLK, BUSY and DONE are all 0.
  - Pattern registers, readback registers and counters are all cleared to 0.
- Reset mid-shift: the shift aborts immediately, outputs go to their reset values, and no DONE pulse is generated.
- Synchronizer: BKY_RTN passes through a 2-flop synchronizer per bit. The sampling points below use the synchronized value.
- Pattern write: WR_EN=1 in IDLE loads pat[WR_CHIP] <= WR_DATA.
  - WR_EN is ignored while BUSY=1.
  - WR_CHIP values of 0 or greater than NCHIP are ignored.
- Readback: RD_DATA = rb[RD_CHIP], combinational from registers. An out-of-range RD_CHIP gives 0.
- State machine: IDLE -> LOW -> HIGH -> (LOW | FIN) -> IDLE.
  - IDLE:
    - On START, latch mask <= CHIP_MASK, set bitcnt=0 and divcnt=0, and go to LOW.
    - Set BUSY=1 on the same edge.
    - If CHIP_MASK is all zeros, go straight to FIN instead of LOW.
  - LOW, lasting CLK_DIV cycles:
    - BKY_CLK=0.
    - TO_BKY[i] = mask[i] ? sh[i][NBITS-1] : 0, where sh is a working copy of pat loaded at START.
  - HIGH, lasting CLK_DIV cycles:
    - BKY_CLK[i] = mask[i].
    - TO_BKY is held stable throughout.
  - On the last cycle of HIGH, for each masked chip:
    - sh[i] <= {sh[i][NBITS-2:0], 1'b0}.
    - cap[i] <= {cap[i][NBITS-2:0], rtn_sync[i]}.
    - Then bitcnt increments.
    - If bitcnt is now NBITS, go to FIN; otherwise go to LOW.
  - FIN, one cycle:
    - rb[i] <= cap[i] for masked chips; unmasked chips keep their rb.
    - DONE=1, BUSY goes to 0, next state is IDLE.
- Masked chips keep BKY_CLK=0 and TO_BKY=0 for the entire shift. Their pat and rb registers are unchanged.
- pat is not modified by a shift, so the same pattern can be shifted again.
- START while BUSY=1 is ignored.
- START and WR_EN in the same IDLE cycle: the write takes effect and the shift uses the old pattern, because sh is loaded from pat before the write lands.
- Timing:
  - One bit takes 2·CLK_DIV cycles; a full shift takes 2·CLK_DIV·NBITS cycles plus one FIN cycle.
  - From the START edge to the DONE pulse is 2·CLK_DIV·NBITS+1 cycles: 385 with the defaults.
- Because the chain is NBITS long, rb holds the chip's previous register contents, MSB first.
- Widths:
  - divcnt is $clog2(CLK_DIV) bits.
  - bitcnt is $clog2(NBITS+1) bits.
  - Both counters wrap only through explicit reload.

Decomposition:
- Package bky_pkg holds:
  - constants BKY_NCHIP=6 and BKY_NBITS=48;
  - the state enum {IDLE, LOW, HIGH, FIN};
  - the typedef bky_word_t = logic [BKY_NBITS-1:0].
- One sub-module, bky_chan: the per-chip sh/cap shift pair plus the 2-flop synchronizer. It is instantiated NCHIP times, with the shared FSM and counters in the top level.

Test Plan:
- Reset: RST_B=0 at an arbitrary point mid-shift. Required: TO_BKY=0, BKY_CLK=0, BUSY=0, RD_DATA=0 with no clock edge needed; no DONE pulse follows.
- Loopback:
  - Setup: BKY_RTN tied to TO_BKY through a 48-stage model per chip. Write pat[1]=48'hA5A5_0F0F_1234 and pat[6]=48'hFFFF_0000_8001. Set CHIP_MASK=6'h3F and pulse START.
  - First START: DONE arrives 385 cycles after START; rb[1]=0 and rb[6]=0.
  - Second START: rb[1]=48'hA5A5_0F0F_1234 and rb[6]=48'hFFFF_0000_8001.
- Waveform: with pat[3]=48'h8000_0000_0001, check BKY_CLK[3] is low for 4 cycles and high for 4 cycles, 48 rising edges in total. TO_BKY[3]=1 during bit 0 and bit 47, and 0 during bits 1..46.
- Mask: CHIP_MASK=6'b000100. Chips 1,2,4,5,6 see BKY_CLK=0 for the whole shift and their rb values are unchanged. The all-zero mask gives DONE one cycle after the START edge with no BKY_CLK edges.
- Collisions:
  - START during BUSY: ignored, and DONE pulses only once.
  - WR_EN during BUSY: pat is unchanged.
  - START with WR_EN in the same cycle (WR_CHIP=2, pat[2] old value X): the shifted data is X and pat[2] ends up as the new value.
- Synchronizer: toggle BKY_RTN asynchronously, changing only outside the last 3 cycles of HIGH. The captured bits match the stable value present at each HIGH end.

Source files
------------

// File: rtl/bky_pkg.sv
// Shared constants and types for the Buckeye configuration shift controller.
package bky_pkg;
  localparam int BKY_NCHIP = 6;
  localparam int BKY_NBITS = 48;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} bky_state_t;

  typedef logic [BKY_NBITS-1:0] bky_word_t;
endpackage

// File: rtl/bky_chan.sv
// One Buckeye channel: outgoing pattern shifter, return capture shifter and
// the two-flop synchronizer for the asynchronous return line.
module bky_chan import bky_pkg::*; #(
  parameter int NBITS = BKY_NBITS
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             load,
  input  logic             step,
  input  logic             rtn,
  input  logic [NBITS-1:0] pat,
  output logic             msb,
  output logic [NBITS-1:0] cap
);
  logic [NBITS-1:0] sh;
  logic [1:0]       rtn_ff;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sh     <= '0;
      cap    <= '0;
      rtn_ff <= '0;
    end else begin
      rtn_ff <= {rtn_ff[0], rtn};
      // load wins: a shift step can never coincide with START in IDLE
      if (load) begin
        sh <= pat;
      end else if (step) begin
        sh  <= {sh[NBITS-2:0], 1'b0};
        cap <= {cap[NBITS-2:0], rtn_ff[1]};
      end
    end
  end

  assign msb = sh[NBITS-1];
endmodule

// File: rtl/buckeye_shift_ctrl.sv
// Serial configuration controller for the Buckeye amplifier chips: shared
// bit-clock FSM plus per-chip pattern/readback registers and channels.
module buckeye_shift_ctrl import bky_pkg::*; #(
  parameter int NCHIP   = BKY_NCHIP,
  parameter int NBITS   = BKY_NBITS,
  parameter int CLK_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             START,
  input  logic [NCHIP:1]   CHIP_MASK,
  input  logic             WR_EN,
  input  logic [2:0]       WR_CHIP,
  input  logic [NBITS-1:0] WR_DATA,
  input  logic [2:0]       RD_CHIP,
  output logic [NBITS-1:0] RD_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [NCHIP:1]   TO_BKY,
  output logic [NCHIP:1]   BKY_CLK,
  input  logic [NCHIP:1]   BKY_RTN
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NBITS+1);

  bky_state_t                  state;
  logic [NCHIP:1]              mask;
  logic [DW-1:0]               divcnt;
  logic [BW-1:0]               bitcnt;
  logic                        hi_phase;
  logic                        shifting;
  logic [NCHIP:1][NBITS-1:0]   pat;
  logic [NCHIP:1][NBITS-1:0]   rb;
  logic [NCHIP:1][NBITS-1:0]   cap;
  logic [NCHIP:1]              msb;
  logic [NCHIP:1]              step_vec;
  logic                        div_last;
  logic                        step;
  logic                        start_go;
  logic                        wr_go;

  assign div_last = (divcnt == DW'(CLK_DIV-1));
  assign step     = (state == HIGH) && div_last;
  assign start_go = (state == IDLE) && START;
  assign wr_go    = (state == IDLE) && WR_EN;
  assign step_vec = {NCHIP{step}} & mask;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state    <= IDLE;
      mask     <= '0;
      divcnt   <= '0;
      bitcnt   <= '0;
      hi_phase <= 1'b0;
      shifting <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          mask   <= CHIP_MASK;
          bitcnt <= '0;
          divcnt <= '0;
          BUSY   <= 1'b1;
          if (CHIP_MASK == '0) begin
            state <= FIN;
          end else begin
            state    <= LOW;
            shifting <= 1'b1;
          end
        end
        LOW: if (div_last) begin
          divcnt   <= '0;
          hi_phase <= 1'b1;
          state    <= HIGH;
        end else begin
          divcnt <= divcnt + 1'b1;
        end
        HIGH: if (div_last) begin
          divcnt   <= '0;
          hi_phase <= 1'b0;
          bitcnt   <= bitcnt + 1'b1;
          if (bitcnt == BW'(NBITS-1)) begin
            state    <= FIN;
            shifting <= 1'b0;
          end else begin
            state <= LOW;
          end
        end else begin
          divcnt <= divcnt + 1'b1;
        end
        FIN: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Out-of-range WR_CHIP simply matches no chip.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      pat <= '0;
      rb  <= '0;
    end else begin
      for (int i = 1; i <= NCHIP; i++) begin
        if (wr_go && WR_CHIP == 3'(i)) pat[i] <= WR_DATA;
        if (state == FIN && mask[i]) rb[i] <= cap[i];
      end
    end
  end

  always_comb begin
    RD_DATA = '0;
    for (int i = 1; i <= NCHIP; i++)
      if (RD_CHIP == 3'(i)) RD_DATA = rb[i];
  end

  // Pad-side outputs are pure AND terms of flops, so they cannot glitch on decode.
  assign TO_BKY  = shifting ? (mask & msb) : '0;
  assign BKY_CLK = hi_phase ? mask : '0;

  bky_chan #(.NBITS(NBITS)) u_chan [NCHIP:1] (
    .gclk   (CLK),
    .grst_n (RST_B),
    .load   (start_go),
    .step   (step_vec),
    .rtn    (BKY_RTN),
    .pat    (pat),
    .msb    (msb),
    .cap    (cap)
  );
endmodule

// File: tb/tb_buckeye_shift_ctrl.sv
// Scoreboard bench for buckeye_shift_ctrl with a per-chip 48-stage loopback model.
module tb_buckeye_shift_ctrl;
  import bky_pkg::*;
  localparam int NCHIP = 6;
  localparam int NBITS = 48;
  localparam int CLK_DIV = 4;
  localparam int SHIFT_LAT = 2*CLK_DIV*NBITS + 1;

  logic CLK = 1'b0, RST_B = 1'b1, START = 1'b0, WR_EN = 1'b0;
  logic [NCHIP:1] CHIP_MASK = '0, TO_BKY, BKY_CLK, BKY_RTN;
  logic [2:0] WR_CHIP = '0, RD_CHIP = 3'd1;
  bky_word_t WR_DATA = '0, RD_DATA;
  logic BUSY, DONE;

  logic [NCHIP:1] loop_rtn, rtn_drv = '0;
  logic sync_mode = 1'b0;

  always #5 CLK = ~CLK;

  buckeye_shift_ctrl #(.NCHIP(NCHIP), .NBITS(NBITS), .CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .RST_B(RST_B), .START(START), .CHIP_MASK(CHIP_MASK),
    .WR_EN(WR_EN), .WR_CHIP(WR_CHIP), .WR_DATA(WR_DATA),
    .RD_CHIP(RD_CHIP), .RD_DATA(RD_DATA), .BUSY(BUSY), .DONE(DONE),
    .TO_BKY(TO_BKY), .BKY_CLK(BKY_CLK), .BKY_RTN(BKY_RTN)
  );

  // Chip model: samples data on the rising shift clock, advances on the falling one.
  for (genvar g = 1; g <= NCHIP; g++) begin : g_chip
    logic d;
    bky_word_t s;
    always @(posedge BKY_CLK[g]) d <= TO_BKY[g];
    always @(negedge BKY_CLK[g] or negedge RST_B)
      if (!RST_B) s <= '0;
      else        s <= {s[NBITS-2:0], d};
    assign loop_rtn[g] = s[NBITS-1];
  end
  assign BKY_RTN = sync_mode ? rtn_drv : loop_rtn;

  typedef struct packed {
    logic [NCHIP:1][NBITS-1:0] rb;
    logic [NCHIP:1][NBITS-1:0] tx;
    logic [NCHIP:1]            mask;
  } exp_t;

  exp_t sbq[$];
  logic [NCHIP:1][NBITS-1:0] pat_m = '0, rb_m = '0, chip_m = '0;
  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wr(input int chip, input bky_word_t d);
    WR_EN = 1'b1; WR_CHIP = 3'(chip); WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
    if (chip >= 1 && chip <= NCHIP) pat_m[chip] = d;
  endtask

  task automatic run_shift(input logic [NCHIP:1] m, input bit sync, input int poke_n,
                           input bit same_wr, input bky_word_t same_data, input int rst_at);
    exp_t e;
    logic [NCHIP:1][NBITS-1:0] rnd, tx_seen;
    logic [NCHIP:1] prev_clk, hold;
    int rises [NCHIP:1];
    int hi_len [NCHIP:1];
    int lo_len [NCHIP:1];
    int run_err, lat, extra, b;
    for (int i = 1; i <= NCHIP; i++) begin
      rnd[i] = NBITS'({$urandom(), $urandom()});
      e.tx[i] = m[i] ? pat_m[i] : '0;
      e.rb[i] = m[i] ? (sync ? rnd[i] : chip_m[i]) : rb_m[i];
      tx_seen[i] = '0; rises[i] = 0; hi_len[i] = 0; lo_len[i] = 0;
    end
    e.mask = m;
    if (rst_at < 0) sbq.push_back(e);
    CHIP_MASK = m; START = 1'b1; sync_mode = sync; rtn_drv = '0;
    if (same_wr) begin
      WR_EN = 1'b1; WR_CHIP = 3'd2; WR_DATA = same_data; pat_m[2] = same_data;
    end
    @(posedge CLK); #1;
    START = 1'b0; WR_EN = 1'b0;
    prev_clk = '0; hold = '0; run_err = 0; lat = -1;
    for (int n = 0; n <= SHIFT_LAT + 20; n++) begin
      @(negedge CLK);
      if (n == 0) check("busy_during_shift", BUSY, 1'b1);
      for (int i = 1; i <= NCHIP; i++) begin
        if (!m[i] && TO_BKY[i]) run_err++;
        if (BKY_CLK[i] && !prev_clk[i]) begin
          rises[i]++;
          if (lo_len[i] != CLK_DIV) run_err++;
          tx_seen[i] = {tx_seen[i][NBITS-2:0], TO_BKY[i]};
          hold[i] = TO_BKY[i]; hi_len[i] = 1;
        end else if (BKY_CLK[i]) begin
          hi_len[i]++;
          if (TO_BKY[i] != hold[i]) run_err++;
        end else if (prev_clk[i]) begin
          if (hi_len[i] != CLK_DIV) run_err++;
          lo_len[i] = 1;
        end else begin
          lo_len[i]++;
        end
      end
      prev_clk = BKY_CLK;
      if (DONE) begin lat = n; break; end
      if (n == rst_at) begin
        RST_B = 1'b0; #1;
        check("rst_mid_to_bky", TO_BKY, '0);
        check("rst_mid_bky_clk", BKY_CLK, '0);
        check("rst_mid_busy", BUSY, 1'b0);
        check("rst_mid_rd_data", RD_DATA, '0);
        repeat (3) @(negedge CLK);
        RST_B = 1'b1;
        pat_m = '0; rb_m = '0; chip_m = '0;
        extra = 0;
        repeat (SHIFT_LAT + 10) begin @(negedge CLK); if (DONE) extra++; end
        check("no_done_after_rst", extra, 0);
        check("idle_after_rst", BUSY, 1'b0);
        return;
      end
      b = n / (2*CLK_DIV);
      if (sync && (n % (2*CLK_DIV)) == 1 && b < NBITS) begin
        #($urandom_range(1, 4));
        for (int i = 1; i <= NCHIP; i++) rtn_drv[i] = rnd[i][NBITS-1-b];
      end
      if (n == poke_n) begin
        START = 1'b1; WR_EN = 1'b1; WR_CHIP = 3'd5; WR_DATA = ~pat_m[5];
        @(posedge CLK); #1;
        START = 1'b0; WR_EN = 1'b0;
      end
    end
    check("done_latency", lat, (m == '0) ? 1 : SHIFT_LAT);
    extra = 0;
    repeat (12) begin @(negedge CLK); if (DONE) extra++; end
    check("single_done", extra, 0);
    check("idle_after_done", BUSY, 1'b0);
    check("waveform_shape", run_err, 0);
    sync_mode = 1'b0;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      for (int i = 1; i <= NCHIP; i++) begin
        RD_CHIP = 3'(i); #1;
        check($sformatf("rb%0d", i), RD_DATA, e.rb[i]);
        check($sformatf("tx%0d", i), tx_seen[i], e.tx[i]);
        check($sformatf("rises%0d", i), rises[i], e.mask[i] ? NBITS : 0);
        rb_m[i] = e.rb[i];
        if (e.mask[i]) chip_m[i] = e.tx[i];
      end
    end
    RD_CHIP = 3'd1;
    @(negedge CLK);
  endtask

  initial begin
    #2 RST_B = 1'b0;
    #1;
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_to_bky", TO_BKY, '0);
    check("rst_bky_clk", BKY_CLK, '0);
    check("rst_rd_data", RD_DATA, '0);
    repeat (3) @(negedge CLK);
    RST_B = 1'b1;
    @(negedge CLK);

    wr(1, 48'hA5A5_0F0F_1234);
    wr(6, 48'hFFFF_0000_8001);
    wr(3, 48'h8000_0000_0001);
    wr(2, NBITS'({$urandom(), $urandom()}));
    wr(4, NBITS'({$urandom(), $urandom()}));
    wr(5, NBITS'({$urandom(), $urandom()}));
    wr(0, 48'hDEAD_BEEF_CAFE);
    wr(7, 48'h1357_9BDF_2468);

    run_shift(6'h3F, 0, -1, 0, '0, -1);
    run_shift(6'h3F, 0, -1, 0, '0, -1);

    RD_CHIP = 3'd0; #1;
    check("rd_chip0", RD_DATA, '0);
    RD_CHIP = 3'd7; #1;
    check("rd_chip7", RD_DATA, '0);
    RD_CHIP = 3'd1;
    @(negedge CLK);

    wr(3, 48'h0123_4567_89AB);
    run_shift(6'b000100, 0, -1, 0, '0, -1);
    run_shift(6'b000000, 0, -1, 0, '0, -1);
    run_shift(6'h3F, 0, 50, 0, '0, -1);
    run_shift(6'h3F, 0, -1, 1, 48'h5A5A_C3C3_0FF0, -1);
    run_shift(6'b000010, 0, -1, 0, '0, -1);
    run_shift(6'h3F, 1, -1, 0, '0, -1);
    run_shift(6'h3F, 0, -1, 0, '0, 101);
    run_shift(6'h3F, 0, -1, 0, '0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
